// File: rtl/switch_debounce_toggle_if.sv
// switch_debounce_toggle_if
// Bundles the four raw switch levels, the four LED outputs, the optional
// press strobes (present only when SWITCH_PRESS_PULSE_EN is defined) and a
// debug view of every channel's debounce FSM.
//
// Signalling: there is no valid/ready handshake on this bundle. Every signal
// is a plain level. Switch inputs may change at any time, asynchronously to
// the clock. LED, strobe and debug outputs are registered in the clock domain
// and change only just after a rising edge.
//
// The master modport is the switch/LED side (board or bench). The slave
// modport is the debouncer.
interface switch_debounce_toggle_if;
  logic       i_Switch_1;
  logic       i_Switch_2;
  logic       i_Switch_3;
  logic       i_Switch_4;
  logic       o_LED_1;
  logic       o_LED_2;
  logic       o_LED_3;
  logic       o_LED_4;
`ifdef SWITCH_PRESS_PULSE_EN
  logic [3:0] o_Press_Pulse;
`endif
  // Debounced level per channel; bit n-1 belongs to channel n.
  logic [3:0] dbg_deb;
  // Per-channel FSM state, 1 = COUNTING, 0 = STABLE.
  logic [3:0] dbg_counting;

`ifdef SWITCH_PRESS_PULSE_EN
  modport master (
    output i_Switch_1, i_Switch_2, i_Switch_3, i_Switch_4,
    input  o_LED_1, o_LED_2, o_LED_3, o_LED_4,
    input  o_Press_Pulse,
    input  dbg_deb, dbg_counting
  );

  modport slave (
    input  i_Switch_1, i_Switch_2, i_Switch_3, i_Switch_4,
    output o_LED_1, o_LED_2, o_LED_3, o_LED_4,
    output o_Press_Pulse,
    output dbg_deb, dbg_counting
  );
`else
  modport master (
    output i_Switch_1, i_Switch_2, i_Switch_3, i_Switch_4,
    input  o_LED_1, o_LED_2, o_LED_3, o_LED_4,
    input  dbg_deb, dbg_counting
  );

  modport slave (
    input  i_Switch_1, i_Switch_2, i_Switch_3, i_Switch_4,
    output o_LED_1, o_LED_2, o_LED_3, o_LED_4,
    output dbg_deb, dbg_counting
  );
`endif
endinterface

// File: rtl/switch_debounce_toggle.sv
// switch_debounce_toggle
// This module has four independent push-switch channels. Each channel does
// the following:
//   raw pin -> 2-flop synchronizer -> debounce FSM -> LED toggle on release.
// A new synchronized level is accepted only after it has persisted for
// DEBOUNCE_LIMIT consecutive cycles. The counter never exceeds
// DEBOUNCE_LIMIT-1.
// Optional feature macro: SWITCH_PRESS_PULSE_EN. It adds o_Press_Pulse, which
// gives a one-cycle strobe on the edge where a debounced press is accepted.
module switch_debounce_toggle #(
  parameter int DEBOUNCE_LIMIT = 250000
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst,
  switch_debounce_toggle_if.slave sw_if
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_LIMIT + 1);
  // On the edge where the counter holds this value, the pending level is accepted.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_LIMIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // STABLE: counter is 0 and sync2 matches deb.
  // COUNTING: a mismatch run is in progress.
  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_COUNTING = 1'b1
  } deb_state_e;

  logic [3:0] sw_raw;
  logic [3:0] deb_vec;
  logic [3:0] led_vec;
  logic [3:0] counting_vec;
`ifdef SWITCH_PRESS_PULSE_EN
  logic [3:0] press_vec;
`endif

  assign sw_raw = {sw_if.i_Switch_4, sw_if.i_Switch_3,
                   sw_if.i_Switch_2, sw_if.i_Switch_1};

  for (genvar ch = 0; ch < 4; ch++) begin : g_ch
    logic             sync1_q;
    logic             sync2_q;
    logic             deb_q;
    logic             led_q;
    logic [CNT_W-1:0] cnt_q;
    deb_state_e       state_q;
`ifdef SWITCH_PRESS_PULSE_EN
    logic             press_q;
`endif

    // Per-channel synchronizer, debounce FSM, LED toggle and press strobe.
    // All of them are registered together.
    always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
        deb_q   <= 1'b0;
        led_q   <= 1'b0;
        cnt_q   <= '0;
        state_q <= ST_STABLE;
`ifdef SWITCH_PRESS_PULSE_EN
        press_q <= 1'b0;
`endif
      end else begin
        sync1_q <= sw_raw[ch];
        sync2_q <= sync1_q;
`ifdef SWITCH_PRESS_PULSE_EN
        press_q <= 1'b0;
`endif
        case (state_q)
          ST_STABLE: begin
            if (sync2_q != deb_q) begin
              // First cycle of a mismatch run. DEBOUNCE_LIMIT >= 2, so
              // this cycle can never be the accepting cycle.
              cnt_q   <= CNT_ONE;
              state_q <= ST_COUNTING;
            end else begin
              cnt_q   <= '0;
              state_q <= ST_STABLE;
            end
          end
          ST_COUNTING: begin
            if (sync2_q == deb_q) begin
              // The bounce returned to the accepted level: drop the partial count.
              cnt_q   <= '0;
              state_q <= ST_STABLE;
            end else if (cnt_q == CNT_LAST) begin
              // DEBOUNCE_LIMIT consecutive mismatch cycles: accept the new level.
              deb_q   <= sync2_q;
              cnt_q   <= '0;
              state_q <= ST_STABLE;
              if (!sync2_q) begin
                // Debounced release toggles the LED.
                led_q <= ~led_q;
              end
`ifdef SWITCH_PRESS_PULSE_EN
              // Debounced press fires the one-cycle strobe.
              press_q <= sync2_q;
`endif
            end else begin
              cnt_q   <= cnt_q + CNT_ONE;
              state_q <= ST_COUNTING;
            end
          end
          default: begin
            cnt_q   <= '0;
            state_q <= ST_STABLE;
          end
        endcase
      end
    end

    assign deb_vec[ch]      = deb_q;
    assign led_vec[ch]      = led_q;
    assign counting_vec[ch] = (state_q == ST_COUNTING);
`ifdef SWITCH_PRESS_PULSE_EN
    assign press_vec[ch]    = press_q;
`endif
  end

  assign sw_if.o_LED_1      = led_vec[0];
  assign sw_if.o_LED_2      = led_vec[1];
  assign sw_if.o_LED_3      = led_vec[2];
  assign sw_if.o_LED_4      = led_vec[3];
  assign sw_if.dbg_deb      = deb_vec;
  assign sw_if.dbg_counting = counting_vec;
`ifdef SWITCH_PRESS_PULSE_EN
  assign sw_if.o_Press_Pulse = press_vec;
`endif

endmodule

// File: tb/tb_switch_debounce_toggle.sv
// tb_switch_debounce_toggle
// Uses DEBOUNCE_LIMIT = 4. Each table row drives reset and the switches,
// holds them for n rising edges, and then compares the debounced levels,
// the LEDs and (with SWITCH_PRESS_PULSE_EN) the cumulative per-channel press
// strobe counts. Expected values are derived by hand from the channel timing:
// a new pin level is accepted on the 6th edge after the first edge that
// samples it.
module tb_switch_debounce_toggle;
  localparam int LIMIT = 4;

  typedef struct {
    string      name;
    logic       rst;
    logic [3:0] sw;
    int         n;
    logic [3:0] exp_deb;
    logic [3:0] exp_led;
    logic [15:0] exp_pcnt;  // nibble n-1 = press strobes seen on channel n
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] led_vec;
  logic [7:0] exp_q[$];
  vec_t       vecs[$];
  int         n_vec = 0;
  int         n_err = 0;

  switch_debounce_toggle_if bus ();

  switch_debounce_toggle #(.DEBOUNCE_LIMIT(LIMIT)) dut (
    .i_Clk (clk),
    .i_Rst (rst),
    .sw_if (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  assign led_vec = {bus.o_LED_4, bus.o_LED_3, bus.o_LED_2, bus.o_LED_1};

`ifdef SWITCH_PRESS_PULSE_EN
  int pcnt[4] = '{default: 0};

  // Count strobes just after each edge so the negedge checks see fresh totals.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 4; i++) begin
      if (bus.o_Press_Pulse[i] === 1'b1) pcnt[i] <= pcnt[i] + 1;
    end
  end

  task automatic check_pcnt(input string name, input logic [15:0] exp);
    logic [15:0] act;
    act = {4'(pcnt[3]), 4'(pcnt[2]), 4'(pcnt[1]), 4'(pcnt[0])};
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: press strobe counts got %h expected %h", name, act, exp);
    end
  endtask
`endif

  // ---------------- driver tasks ----------------
  task automatic drive(input logic r, input logic [3:0] s);
    rst            = r;
    bus.i_Switch_1 = s[0];
    bus.i_Switch_2 = s[1];
    bus.i_Switch_3 = s[2];
    bus.i_Switch_4 = s[3];
  endtask

  task automatic add_vec(input string nm, input logic r, input logic [3:0] s,
                         input int n, input logic [3:0] d, input logic [3:0] l,
                         input logic [15:0] p);
    vec_t v;
    v.name = nm; v.rst = r; v.sw = s; v.n = n;
    v.exp_deb = d; v.exp_led = l; v.exp_pcnt = p;
    vecs.push_back(v);
  endtask

  // ---------------- scoreboard ----------------
  task automatic check_out(input string name);
    logic [7:0] exp;
    logic [7:0] act;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL %s: scoreboard empty, got deb/led %h", name, {bus.dbg_deb, led_vec});
    end else begin
      exp = exp_q.pop_front();
      act = {bus.dbg_deb, led_vec};
      if (act !== exp) begin
        n_err++;
        $display("FAIL %s: deb/led got %h expected %h", name, act, exp);
      end
    end
  endtask

  // Watchdog: the run is a few hundred cycles, so this bound is never reached normally.
  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    int         run[4];
    logic [3:0] s;
    run = '{default: 0};
    drive(1'b1, 4'hF);

    // All switches are held through reset. All four channels press after
    // release, and then all four release together.
    add_vec("reset_hold",      1, 4'hF,  3, 4'h0, 4'h0, 16'h0000);
    add_vec("post_reset",      0, 4'hF,  1, 4'h0, 4'h0, 16'h0000);
    add_vec("held_edge5",      0, 4'hF,  4, 4'h0, 4'h0, 16'h0000);
    add_vec("held_edge6",      0, 4'hF,  1, 4'hF, 4'h0, 16'h1111);
    add_vec("held_steady",     0, 4'hF, 10, 4'hF, 4'h0, 16'h1111);
    add_vec("rel_all_edge5",   0, 4'h0,  5, 4'hF, 4'h0, 16'h1111);
    add_vec("rel_all_edge6",   0, 4'h0,  1, 4'h0, 4'hF, 16'h1111);
    add_vec("reset2",          1, 4'h0,  1, 4'h0, 4'h0, 16'h1111);
    // Clean press and clean release on switch 1.
    add_vec("sw1_press_e5",    0, 4'h1,  5, 4'h0, 4'h0, 16'h1111);
    add_vec("sw1_press_e6",    0, 4'h1,  1, 4'h1, 4'h0, 16'h1112);
    add_vec("sw1_hold",        0, 4'h1, 14, 4'h1, 4'h0, 16'h1112);
    add_vec("sw1_rel_e5",      0, 4'h0,  5, 4'h1, 4'h0, 16'h1112);
    add_vec("sw1_rel_e6",      0, 4'h0,  1, 4'h0, 4'h1, 16'h1112);
    add_vec("sw1_idle",        0, 4'h0, 14, 4'h0, 4'h1, 16'h1112);
    // Bounce on switch 2: 1,0,1,1,0,1 and then 0. Mismatch runs are 1, 2 and 1.
    add_vec("sw2_b1",          0, 4'h2,  1, 4'h0, 4'h1, 16'h1112);
    add_vec("sw2_b0",          0, 4'h0,  1, 4'h0, 4'h1, 16'h1112);
    add_vec("sw2_b11",         0, 4'h2,  2, 4'h0, 4'h1, 16'h1112);
    add_vec("sw2_b0b",         0, 4'h0,  1, 4'h0, 4'h1, 16'h1112);
    add_vec("sw2_b1b",         0, 4'h2,  1, 4'h0, 4'h1, 16'h1112);
    add_vec("sw2_settle",      0, 4'h0, 10, 4'h0, 4'h1, 16'h1112);
    // The longest rejected run is LIMIT-1 cycles.
    add_vec("sw2_run3",        0, 4'h2,  3, 4'h0, 4'h1, 16'h1112);
    add_vec("sw2_run3_back",   0, 4'h0,  6, 4'h0, 4'h1, 16'h1112);
    // Switch 3 is pressed, reset is asserted mid-count, and the switch stays pressed.
    add_vec("sw3_precount",    0, 4'h4,  3, 4'h0, 4'h1, 16'h1112);
    add_vec("sw3_mid_reset",   1, 4'h4,  1, 4'h0, 4'h0, 16'h1112);
    add_vec("sw3_post_rst_e5", 0, 4'h4,  5, 4'h0, 4'h0, 16'h1112);
    add_vec("sw3_post_rst_e6", 0, 4'h4,  1, 4'h4, 4'h0, 16'h1212);
    add_vec("sw3_hold",        0, 4'h4, 10, 4'h4, 4'h0, 16'h1212);
    add_vec("sw3_rel_e5",      0, 4'h0,  5, 4'h4, 4'h0, 16'h1212);
    add_vec("sw3_rel_e6",      0, 4'h0,  1, 4'h0, 4'h4, 16'h1212);

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].sw);
      exp_q.push_back({vecs[i].exp_deb, vecs[i].exp_led});
      repeat (vecs[i].n) @(posedge clk);
      @(negedge clk);
      check_out(vecs[i].name);
`ifdef SWITCH_PRESS_PULSE_EN
      check_pcnt(vecs[i].name, vecs[i].exp_pcnt);
`endif
    end

    // Random bounce on every channel. Each pressed run is at most LIMIT-1
    // cycles long, so nothing may ever be accepted.
    for (int c = 0; c < 60; c++) begin
      for (int k = 0; k < 4; k++) begin
        if (run[k] < LIMIT - 1 && $urandom_range(0, 1) == 1) begin
          s[k] = 1'b1;
          run[k]++;
        end else begin
          s[k] = 1'b0;
          run[k] = 0;
        end
      end
      drive(1'b0, s);
      exp_q.push_back({4'h0, 4'h4});
      @(posedge clk);
      @(negedge clk);
      check_out("rand_bounce");
    end

    drive(1'b0, 4'h0);
    exp_q.push_back({4'h0, 4'h4});
    repeat (6) @(posedge clk);
    @(negedge clk);
    check_out("rand_settle");
    n_vec++;
    if (bus.dbg_counting !== 4'h0) begin
      n_err++;
      $display("FAIL settle_fsm: counting state got %h expected %h", bus.dbg_counting, 4'h0);
    end
`ifdef SWITCH_PRESS_PULSE_EN
    check_pcnt("rand_settle", 16'h1212);
`endif

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/switch_debounce_toggle.md
SWITCH_DEBOUNCE_TOGGLE -- requirements
Module: switch_debounce_toggle

Interface
REQ-001 The block SHALL have one parameter: DEBOUNCE_LIMIT, default 250000, meaning the number of consecutive clock cycles a new synchronized switch level must persist before it is accepted (10 ms at 25 MHz); legal range 2..2^20.
REQ-002 The block SHALL have port i_Clk, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port i_Rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have ports i_Switch_1..i_Switch_4, input, 1 bit each: raw, asynchronous, bouncing push-switch levels, where 1 = pressed.
REQ-005 The block SHALL have ports o_LED_1..o_LED_4, output, 1 bit each: per-channel registered toggle state driving the LEDs.
REQ-006 The block SHALL have port o_Press_Pulse, output, 4 bits, present only under SWITCH_PRESS_PULSE_EN: one-cycle debounced-press strobes, with bit n-1 belonging to channel n.

Function
REQ-007 The block SHALL handle each of the four channels independently and identically; no state is shared between channels.
REQ-008 Each channel SHALL pass its raw input through a 2-flop synchronizer (sync1 feeding sync2) before any other logic uses it.
REQ-009 Each channel SHALL hold a debounced-level register (deb) and a counter of width clog2(DEBOUNCE_LIMIT+1).
REQ-010 Counter update rule when sync2 equals deb: counter SHALL load 0.
REQ-011 Counter update rule when sync2 differs from deb: counter SHALL increment by 1.
REQ-012 On the edge where sync2 differs from deb and counter equals DEBOUNCE_LIMIT-1, deb SHALL load sync2 and counter SHALL load 0; this gives exactly DEBOUNCE_LIMIT consecutive mismatch cycles.
REQ-013 Pin-to-deb latency SHALL be exactly DEBOUNCE_LIMIT+2 rising edges after the first edge that samples the new pin level, provided the level is held steady throughout.
REQ-014 A mismatch lasting fewer than DEBOUNCE_LIMIT cycles SHALL clear the counter on return to the deb level and SHALL NOT change deb, the LED or the pulse.
REQ-015 The counter SHALL never wrap; it SHALL never exceed DEBOUNCE_LIMIT-1.
REQ-016 o_LED_n SHALL invert on the same edge that deb_n transitions from 1 to 0 (debounced release), and SHALL otherwise hold its value.
REQ-017 Simultaneous releases on several channels SHALL toggle every affected LED on the same edge.
REQ-018 Per-channel behaviour SHALL be a 2-state debounce FSM, STABLE (counter 0) and COUNTING (counter > 0), with transitions exactly as in REQ-010..REQ-012.

Reset
REQ-019 While i_Rst=1 at a rising edge, the block SHALL clear sync1, sync2, deb, counter, o_LED_1..4 and o_Press_Pulse to 0.
REQ-020 Reset asserted mid-count SHALL discard the partial count, and the first post-reset mismatch SHALL start from counter 0.
REQ-021 If a switch is held pressed through reset release, the block SHALL register a debounced press DEBOUNCE_LIMIT+2 edges after reset deassertion, and SHALL NOT toggle the LED until the subsequent release.

Configuration
REQ-022 With macro SWITCH_PRESS_PULSE_EN defined, o_Press_Pulse[n-1] SHALL be 1 for exactly one cycle, registered on the edge where deb_n transitions from 0 to 1, and 0 otherwise.
REQ-023 With SWITCH_PRESS_PULSE_EN undefined, the o_Press_Pulse port and its logic SHALL be absent, and all other behaviour SHALL be unchanged.

Verification (DEBOUNCE_LIMIT=4 for all scenarios)
REQ-024 Reset values: hold i_Rst=1 for 3 cycles with all switches=1 -> all LEDs=0 and o_Press_Pulse=0 during reset and on the first cycle after.
REQ-025 Clean press then release on switch 1, each held 20 cycles -> deb_1 rises 6 edges after press sampling; o_LED_1 goes 0->1 exactly 6 edges after release sampling; o_LED_2..4 stay 0.
REQ-026 Bounce rejection on switch 2: pattern 1,0,1,1,0,1 one cycle each, then 0 held -> deb_2, o_LED_2 and pulses never change.
REQ-027 Press switch 3, wait 3 cycles, assert i_Rst for 1 cycle, keep switch 3 pressed -> deb_3 rises 6 edges after reset deassertion; o_Press_Pulse[2] fires once (with macro); o_LED_3 stays 0.
REQ-028 Release switches 1-4 simultaneously after a debounced press on each -> all four LEDs toggle on the same edge; with the macro, exactly four single-cycle press pulses were seen earlier.
REQ-029 Build without SWITCH_PRESS_PULSE_EN and rerun REQ-025 -> LED timing is identical and o_Press_Pulse does not exist.
